// File: rtl/backprop_accumulator.sv
// Lane-wise accumulator for backprop change vectors from the next layer.
// Sums one vector per distinct source, then holds totals on valid/ready.
module backprop_accumulator #(
  parameter int NUM_SOURCES = 4,
  parameter int LANES       = 32,
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 64
) (
  input  logic                              ba_clock,
  input  logic                              ba_reset_n,
  input  logic                              ba_in_valid,
  output logic                              ba_in_ready,
  input  logic [4:0]                        ba_in_source,
  input  logic [LANES-1:0][IN_WIDTH-1:0]    ba_in_change,
  input  logic                              ba_flush,
  output logic                              ba_out_valid,
  input  logic                              ba_out_ready,
  output logic [LANES-1:0][OUT_WIDTH-1:0]   ba_out_backprop,
  output logic [5:0]                        ba_count,
  output logic                              ba_error
);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  localparam logic [5:0] NSRC = 6'(NUM_SOURCES);
  localparam logic [NUM_SOURCES-1:0] ONE  = 1;
  localparam logic [NUM_SOURCES-1:0] FULL = '1;
  localparam int EXT = OUT_WIDTH - IN_WIDTH;

  state_t state, state_n;

  logic [LANES-1:0][OUT_WIDTH-1:0] sums;
  logic [NUM_SOURCES-1:0]          mask;
  logic [NUM_SOURCES-1:0]          src_oh;
  logic accept, in_range, dup, good, last, xfer;

  // Out-of-range sources shift out of the mask width and give zero.
  assign src_oh   = ONE << ba_in_source;
  assign in_range = {1'b0, ba_in_source} < NSRC;
  assign dup      = |(mask & src_oh);
  assign accept   = ba_in_valid & ba_in_ready;
  assign good     = accept & in_range & ~dup;
  assign last     = good & ((mask | src_oh) == FULL);
  assign xfer     = ba_out_valid & ba_out_ready;

  assign ba_out_backprop = sums;

  // State register.
  always_ff @(posedge ba_clock or negedge ba_reset_n) begin
    if (!ba_reset_n) begin
      state <= ACCUM;
    end else begin
      state <= state_n;
    end
  end

  // Next state and handshake outputs; ready stays low while reset is held.
  always_comb begin
    state_n      = state;
    ba_in_ready  = 1'b0;
    ba_out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        ba_in_ready = ba_reset_n;
        if (last) state_n = HOLD;
      end
      HOLD: begin
        ba_out_valid = 1'b1;
        if (xfer) state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
    if (ba_flush) state_n = ACCUM;
  end

  // Sums, source mask, count and the discarded-beat pulse.
  always_ff @(posedge ba_clock or negedge ba_reset_n) begin
    if (!ba_reset_n) begin
      sums     <= '0;
      mask     <= '0;
      ba_count <= '0;
      ba_error <= 1'b0;
    end else begin
      ba_error <= 1'b0;
      if (ba_flush || xfer) begin
        sums     <= '0;
        mask     <= '0;
        ba_count <= '0;
      end else if (good) begin
        for (int k = 0; k < LANES; k++) begin
          sums[k] <= sums[k] +
            {{EXT{ba_in_change[k][IN_WIDTH-1]}}, ba_in_change[k]};
        end
        mask     <= mask | src_oh;
        ba_count <= ba_count + 6'd1;
      end else if (accept) begin
        ba_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_backprop_accumulator.sv
// Directed bench for backprop_accumulator with NUM_SOURCES = 4.
// Table of beats with expected post-edge results plus corner sequences.
module tb_backprop_accumulator;

  localparam int LANES = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [4:0]                in_source;
  logic [LANES-1:0][31:0]    in_change;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES-1:0][63:0]    out_bp;
  logic [5:0]                count;
  logic                      err;

  int total = 0;
  int bad   = 0;

  backprop_accumulator dut (
    .ba_clock       (clk),
    .ba_reset_n     (rst_n),
    .ba_in_valid    (in_valid),
    .ba_in_ready    (in_ready),
    .ba_in_source   (in_source),
    .ba_in_change   (in_change),
    .ba_flush       (flush),
    .ba_out_valid   (out_valid),
    .ba_out_ready   (out_ready),
    .ba_out_backprop(out_bp),
    .ba_count       (count),
    .ba_error       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [4:0]  src;
    logic [31:0] val;
    logic        ordy;
    logic        fl;
    logic        e_err;
    logic [5:0]  e_cnt;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_lane;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic vld, logic [4:0] src,
                              logic [31:0] val, logic ordy,
                              logic fl, logic e_err,
                              logic [5:0] e_cnt, logic e_ov,
                              logic e_ir, logic [63:0] e_lane);
    vec_t v;
    v.vld = vld; v.src = src; v.val = val;
    v.ordy = ordy; v.fl = fl; v.e_err = e_err;
    v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ir = e_ir;
    v.e_lane = e_lane;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [4:0] src,
                       input logic [31:0] val, input logic ordy,
                       input logic fl);
    in_valid  = vld;
    in_source = src;
    in_change = {LANES{val}};
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] sx[4];
    string nm;
    sx[0] = 32'hFFFF_FFFF;
    sx[1] = 32'h8000_0000;
    sx[2] = 32'h7FFF_FFFF;
    sx[3] = 32'd5;

    // basic round, ready already high
    add(1, 0, 1, 1, 0, 0, 1, 0, 1, 64'd1);
    add(1, 1, 2, 1, 0, 0, 2, 0, 1, 64'd3);
    add(1, 2, 3, 1, 0, 0, 3, 0, 1, 64'd6);
    add(1, 3, 4, 1, 0, 0, 4, 1, 0, 64'd10);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 64'd0);
    // duplicate and out-of-range sources
    add(1, 0, 1, 0, 0, 0, 1, 0, 1, 64'd1);
    add(1, 0, 1, 0, 0, 1, 1, 0, 1, 64'd1);
    add(1, 7, 1, 0, 0, 1, 1, 0, 1, 64'd1);
    add(1, 1, 1, 0, 0, 0, 2, 0, 1, 64'd2);
    add(1, 2, 1, 0, 0, 0, 3, 0, 1, 64'd3);
    add(1, 3, 1, 0, 0, 0, 4, 1, 0, 64'd4);
    // backpressure: beats ignored while holding
    for (int i = 0; i < 5; i++)
      add(1, 0, 9, 0, 0, 0, 4, 1, 0, 64'd4);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 64'd0);
    add(1, 0, 2, 0, 0, 0, 1, 0, 1, 64'd2);
    add(1, 1, 2, 0, 0, 0, 2, 0, 1, 64'd4);
    add(1, 2, 2, 0, 0, 0, 3, 0, 1, 64'd6);
    add(1, 3, 2, 0, 0, 0, 4, 1, 0, 64'd8);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 64'd0);
    // flush beats a simultaneous third beat
    add(1, 0, 5, 0, 0, 0, 1, 0, 1, 64'd5);
    add(1, 1, 5, 0, 0, 0, 2, 0, 1, 64'd10);
    add(1, 2, 5, 0, 1, 0, 0, 0, 1, 64'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'd0);
    add(1, 2, 1, 0, 0, 0, 1, 0, 1, 64'd1);
    add(1, 0, 1, 0, 0, 0, 2, 0, 1, 64'd2);
    add(1, 3, 1, 0, 0, 0, 3, 0, 1, 64'd3);
    add(1, 1, 1, 0, 0, 0, 4, 1, 0, 64'd4);
    // flush while holding
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 64'd0);

    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_iready", 64'(in_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_lane0", out_bp[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_iready", 64'(in_ready), 64'd1);

    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].src, tbl[i].val,
            tbl[i].ordy, tbl[i].fl);
      step();
      nm = $sformatf("v%0d", i);
      chk({nm, "_err"}, 64'(err), 64'(tbl[i].e_err));
      chk({nm, "_cnt"}, 64'(count), 64'(tbl[i].e_cnt));
      chk({nm, "_ov"}, 64'(out_valid), 64'(tbl[i].e_ov));
      chk({nm, "_ir"}, 64'(in_ready), 64'(tbl[i].e_ir));
      chk({nm, "_l0"}, out_bp[0], tbl[i].e_lane);
      chk({nm, "_l31"}, out_bp[LANES-1], tbl[i].e_lane);
    end

    // sign extension on lane 0 only
    for (int s = 0; s < 4; s++) begin
      drive(1, 5'(s), 0, 0, 0);
      in_change[0] = sx[s];
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("sx_ov", 64'(out_valid), 64'd1);
    chk("sx_lane0", out_bp[0], 64'h0000_0000_0000_0003);
    chk("sx_lane1", out_bp[1], 64'd0);
    chk("sx_lane31", out_bp[LANES-1], 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sx_xfer_ov", 64'(out_valid), 64'd0);

    // partial negative round checks plain sign extension
    drive(1, 1, 32'hFFFF_FFFE, 0, 0);
    step();
    chk("neg_lane5", out_bp[5], 64'hFFFF_FFFF_FFFF_FFFE);
    drive(0, 0, 0, 0, 1);
    step();
    chk("neg_flush", out_bp[5], 64'd0);

    // async reset while holding
    for (int s = 0; s < 4; s++) begin
      drive(1, 5'(s), 3, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("ar_hold_ov", 64'(out_valid), 64'd1);
    chk("ar_hold_l0", out_bp[0], 64'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 64'(out_valid), 64'd0);
    chk("ar_ir", 64'(in_ready), 64'd0);
    chk("ar_cnt", 64'(count), 64'd0);
    chk("ar_l0", out_bp[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2, 7, 0, 0);
    step();
    chk("ar_new_cnt", 64'(count), 64'd1);
    chk("ar_new_l0", out_bp[0], 64'd7);
    chk("ar_new_err", 64'(err), 64'd0);
    drive(0, 0, 0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/backprop_accumulator.md
Name: backprop_accumulator

Overview:
- Sits directly upstream of each layer's learningNeuron instances on the backprop path.
- Collects the 32-lane, 32-bit backprop-change vectors produced by the NUM_SOURCES learning neurons of the next layer, arriving one vector per handshake.
- Sums them lane-wise into 32 signed 64-bit totals. Lane k total is the 64-bit backprop input for upstream neuron k.
- Holds the completed totals on a valid/ready output until the upstream layer takes them, then starts a new round.

Parameters:
- NUM_SOURCES, 4: number of downstream neurons contributing per round; legal range 1..32.
- LANES, 32: number of lanes, equal to the dendrite count per neuron.
- IN_WIDTH, 32: signed width of each incoming lane value.
- OUT_WIDTH, 64: signed width of each lane total.

Ports:
- ba_clock  input  1  sole clock; rising edge.
- ba_reset_n  input  1  asynchronous, active-low reset.
- ba_in_valid  input  1  vector present on ba_in_change.
- ba_in_ready  output  1  block accepts a vector this cycle.
- ba_in_source  input  5  index of the sending downstream neuron.
- ba_in_change  input  LANES x IN_WIDTH  packed [LANES-1:0][IN_WIDTH-1:0]; signed backprop change per lane.
- ba_flush  input  1  synchronous abort of the current round.
- ba_out_valid  output  1  totals complete and stable.
- ba_out_ready  input  1  consumer takes the totals.
- ba_out_backprop  output  LANES x OUT_WIDTH  packed [LANES-1:0][OUT_WIDTH-1:0]; lane totals.
- ba_count  output  6  number of distinct sources accepted this round.
- ba_error  output  1  one-cycle pulse when an accepted beat is discarded.

Behaviour:
- Reset (ba_reset_n low, asynchronous):
  - state ACCUM; all sums 0; received mask 0; ba_count 0.
  - ba_out_valid 0, ba_error 0, ba_in_ready 0 while reset is held.
  - After release, ba_in_ready is 1 on the first rising edge.
- States: ACCUM, HOLD.
- ACCUM:
  - ba_in_ready = 1.
  - A beat is accepted on a rising edge with ba_in_valid & ba_in_ready.
  - Valid beat (source < NUM_SOURCES and mask bit clear):
    - each lane sum += sign-extend(ba_in_change[k]) to OUT_WIDTH;
    - set mask bit; ba_count += 1.
  - Invalid beat (source >= NUM_SOURCES, or mask bit already set):
    - beat is consumed and sums are unchanged;
    - ba_error = 1 for exactly the following cycle.
  - When the accepted beat sets the final mask bit (mask all ones): next state HOLD.
- HOLD:
  - ba_out_valid = 1; ba_in_ready = 0.
  - ba_out_backprop holds the sums, stable until the transfer.
  - Transfer on a rising edge with ba_out_valid & ba_out_ready; on that edge:
    - sums, mask and ba_count clear to 0; state ACCUM.
  - ba_in_ready is 1 in the next cycle, so there is one bubble cycle between rounds.
- Latency:
  - ba_out_valid rises the cycle after the edge that accepted the final beat.
  - If ba_out_ready is already high, the transfer completes on the following edge.
- ba_out_backprop outside HOLD shows the partial running sums. Consumers use it only when ba_out_valid is 1.
- Arithmetic:
  - Signed two's complement throughout.
  - With NUM_SOURCES <= 32 and 32-bit inputs, 64-bit sums cannot overflow; no saturation logic.
- ba_flush (synchronous):
  - On an edge with ba_flush = 1, in any state: sums, mask and count clear; state ACCUM; ba_out_valid drops the next cycle.
  - Flush wins over a simultaneous input accept (beat lost, no error) and over a simultaneous output transfer (treated as a transfer).
- NUM_SOURCES = 1: every valid beat moves directly to HOLD.
- Reset asserted mid-round or in HOLD: all partial state is lost and the block returns to reset values immediately.

Test Plan:
- Basic round, NUM_SOURCES=4:
  - sources 0..3 send all lanes = 1, 2, 3, 4; ba_out_ready = 1.
  - Expect ba_out_valid on the cycle after the 4th accept, every lane = 10, ba_count = 4.
  - Expect ba_in_ready back to 1 two cycles after the 4th accept.
- Sign extension:
  - lane 0 values 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF, 5 from sources 0..3.
  - Expect lane 0 = 0x0000000000000003 (sum -1 - 2147483648 + 2147483647 + 5 = 3); other lanes 0.
- Duplicate and out-of-range sources:
  - sequence 0, 0, 7, 1, 2, 3 with all lanes = 1.
  - Expect ba_error pulses after the 2nd and 3rd beats; final lanes = 4; ba_count = 4.
- Output backpressure:
  - complete a round with ba_out_ready = 0 for 5 cycles.
  - Expect totals stable, ba_in_ready = 0, and further ba_in_valid ignored.
  - Raise ba_out_ready: transfer on that edge, then a new round starts from 0.
- Flush:
  - after 2 accepted beats, assert ba_flush together with a 3rd beat.
  - Expect ba_count = 0, sums 0, no ba_error.
  - A following full round yields correct totals with no residue.
- Async reset:
  - drop ba_reset_n mid-cycle during HOLD.
  - Expect ba_out_valid = 0 immediately, without waiting for a clock edge.
  - After release, a fresh round accumulates from 0.
